button_event_fsm: RTL
=====================

// Module: button_event_fsm
// PURPOSE
//   Consumes the debounced level from the debouncer and classifies button activity
//   into one-cycle event pulses: press, release, single click, double click, long press.
//   Time windows are counted in m_tick periods, the same tick strobe that drives the debouncer.
//   It sits directly downstream of the debouncer and feeds UI/control logic.
// PARAMETERS
//   CNT_W        8   width of the internal tick counter
//   LONG_TICKS   50  m_ticks held before long_press fires; legal range 1..2^CNT_W-1
//   DCLICK_TICKS 20  m_ticks after release to wait for a second press; legal range 1..2^CNT_W-1
// PORTS
//   clk          in   1  system clock, all state changes on rising edge
//   reset        in   1  asynchronous, active-high; clears all state
//   m_tick       in   1  one-clk timing strobe, same strobe as the debouncer's
//   level        in   1  debounced button level (debouncer curr_level)
//   press_tick   out  1  1-clk pulse on every rising edge of level
//   release_tick out  1  1-clk pulse on every falling edge of level
//   single_click out  1  1-clk pulse: short press with no second press within window
//   double_click out  1  1-clk pulse: second press began within window
//   long_press   out  1  1-clk pulse: level held LONG_TICKS m_ticks
//   busy         out  1  high whenever state != IDLE
//   state_dbg    out  3  current state encoding, for debug/verification
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE (3'd0), cnt 0, lvl_q 0.
//   - Edge detect: lvl_q <= level each clk; rise = level & ~lvl_q; fall = ~level & lvl_q.
//   - Because lvl_q resets to 0, a level already high at reset release gives a press.
//   - All outputs are registered. A condition sampled at edge N drives its pulse high in cycle N..N+1 only.
//   - cnt advances only on clks with m_tick=1 in timed states; it is cleared on every state entry.
//   - States: IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_SECOND=3, SECOND_PRESSED=4.
//   - IDLE: on rise -> PRESSED, press_tick.
//   - PRESSED:
//       fall -> WAIT_SECOND, release_tick.
//       else if m_tick and cnt==LONG_TICKS-1 -> LONG_HELD, long_press.
//       else cnt += m_tick.
//   - LONG_HELD: on fall -> IDLE, release_tick. No click event is ever emitted from this state.
//   - WAIT_SECOND:
//       rise -> SECOND_PRESSED, press_tick and double_click in the same cycle.
//       else if m_tick and cnt==DCLICK_TICKS-1 -> IDLE, single_click.
//       else cnt += m_tick.
//   - SECOND_PRESSED: no timer and no long_press. On fall -> IDLE, release_tick.
//   - Simultaneous events: a level edge always beats a timer expiry in the same cycle.
//       fall + long expiry -> short press.
//       rise + dclick expiry -> double_click, no single_click.
//   - The counter never wraps; the expiry compare precedes the increment.
//   - Reset asserted mid-sequence aborts with no pending pulse emitted, even from WAIT_SECOND.
//   - Events are mutually exclusive per cycle, except press_tick+double_click.
//   - Each rise/fall produces exactly one press_tick/release_tick.
// TESTING (bench: 10 ns clk, m_tick 1 clk wide every 4 clks, LONG_TICKS=4, DCLICK_TICKS=3)
//   1 reset=1 with level=0, then release -> all outputs 0, state_dbg=0, busy=0 until first rise.
//   2 level 0->1 for 6 clks, then 0 ->
//       press_tick 1 clk, release_tick 1 clk;
//       single_click at the 3rd m_tick after release; never double_click/long_press.
//   3 press 6 clks, release 5 clks, press 6 clks, release ->
//       double_click together with the 2nd press_tick; no single_click; state 0 after 2nd release.
//   4 hold level=1 for 30 clks ->
//       long_press exactly once, at the 4th m_tick; state 2;
//       on release, release_tick only and state 0; no click pulse.
//   5 single press/release, assert reset 1 clk after release (state 3) ->
//       no single_click ever; state 0; busy 0.
//   6 2nd rise driven on the same clk as the 3rd m_tick in WAIT_SECOND ->
//       double_click=1, single_click=0.
//   7 reset released with level=1 -> press_tick one clk later; state 1.

Source files
------------

// File: rtl/button_event_if.sv
// Signals between the debounced button source and the event classifier.
// The slave side is the classifier. The master side is whoever drives the level and tick.
interface button_event_if;
  logic       m_tick;
  logic       level;
  logic       press_tick;
  logic       release_tick;
  logic       single_click;
  logic       double_click;
  logic       long_press;
  logic       busy;
  logic [2:0] state_dbg;

  modport master (
    output m_tick, level,
    input  press_tick, release_tick, single_click, double_click, long_press,
           busy, state_dbg
  );

  modport slave (
    input  m_tick, level,
    output press_tick, release_tick, single_click, double_click, long_press,
           busy, state_dbg
  );
endinterface

// File: rtl/button_event_fsm.sv
// Classifies a debounced button level into one-cycle pulses.
// The pulses are press, release, single click, double click and long press.
module button_event_fsm #(
  parameter int CNT_W        = 8,
  parameter int LONG_TICKS   = 50,
  parameter int DCLICK_TICKS = 20
) (
  input  logic          clk,
  input  logic          reset,
  button_event_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lvl_q;
  logic             rise, fall;
  logic             press_r, release_r, single_r, double_r, long_r;
  logic             press_nxt, release_nxt, single_nxt, double_nxt, long_nxt;

  assign rise = bus.level & ~lvl_q;
  assign fall = ~bus.level & lvl_q;

  // Edges are tested before timer expiry, so an edge wins over an expiry in the same cycle.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    single_nxt  = 1'b0;
    double_nxt  = 1'b0;
    long_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nxt   = WAIT_SECOND;
          release_nxt = 1'b1;
        end else if (bus.m_tick && cnt == LONG_LAST) begin
          state_nxt = LONG_HELD;
          long_nxt  = 1'b1;
        end else if (bus.m_tick) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_nxt  = SECOND_PRESSED;
          press_nxt  = 1'b1;
          double_nxt = 1'b1;
        end else if (bus.m_tick && cnt == DCLICK_LAST) begin
          state_nxt  = IDLE;
          single_nxt = 1'b1;
        end else if (bus.m_tick) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every state entry starts its window from zero.
    if (state_nxt != state) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lvl_q     <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      single_r  <= 1'b0;
      double_r  <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lvl_q     <= bus.level;
      press_r   <= press_nxt;
      release_r <= release_nxt;
      single_r  <= single_nxt;
      double_r  <= double_nxt;
      long_r    <= long_nxt;
    end
  end

  assign bus.press_tick   = press_r;
  assign bus.release_tick = release_r;
  assign bus.single_click = single_r;
  assign bus.double_click = double_r;
  assign bus.long_press   = long_r;
  assign bus.busy         = (state != IDLE);
  assign bus.state_dbg    = state;

endmodule
